avalon_master_exram: RTL and testbench
======================================

Name: avalon_master_exram

Overview:
- Avalon-MM master (initiator) that drives the active-low chipselect/write/read bus of the external-RAM Avalon slave bridge.
- Takes block commands from local logic (start address, beat count, direction) and issues one-byte transfers with address auto-increment.
- Write data is streamed in; read data is returned as a stream.
- Read data returns at a fixed latency because the slave has no waitrequest, so reads are pipelined with a valid shift register.

Parameters:
- RD_LAT, 2, cycles from a read-issue cycle to the cycle in which in_avm_readdata is valid and sampled (1..8).
- LEN_W, 8, width of cmd_len; a block is cmd_len+1 beats.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE and not rst; command accepted when cmd_valid&&cmd_ready
- cmd_write  in  1  1=write block, 0=read block
- cmd_addr  in  16  start byte address
- cmd_len  in  LEN_W  beats minus one
- wr_valid  in  1  write byte available
- wr_ready  out  1  write byte consumed this cycle
- wr_data  in  8  write byte
- rd_valid  out  1  read byte valid (one-cycle pulse, no backpressure)
- rd_data  out  8  read byte
- rd_last  out  1  qualifies the final rd_valid of a block
- done  out  1  one-cycle pulse when a block completes
- out_avm_chipselect_n  out  1  active-low chip select
- out_avm_write_n  out  1  active-low write strobe
- out_avm_read_n  out  1  active-low read strobe
- out_avm_address  out  16  byte address
- out_avm_writedata  out  8  write byte
- in_avm_readdata  in  8  read byte from the slave

Behaviour:
- All outputs are registered except cmd_ready and wr_ready.
- Reset values: chipselect_n=1, write_n=1, read_n=1, address=0, writedata=0, rd_valid=0, rd_last=0, done=0; state=IDLE; beat counter=0; read valid pipeline cleared.
- State IDLE: on accept, latch addr and count=cmd_len; go to WR if cmd_write=1, else RD_ISSUE.
- State WR:
  - wr_ready = wr_valid.
  - Each cycle with wr_valid=1, the next edge drives chipselect_n=0, write_n=0, address=addr, writedata=wr_data; then addr+=1 and count-=1.
  - A cycle with wr_valid=0 drives a bubble (chipselect_n=1, write_n=1) and holds addr/count.
  - After the beat with count==0, go to IDLE and pulse done on the edge after the final strobe's cycle.
- State RD_ISSUE:
  - Every cycle drives chipselect_n=0, read_n=0, address=addr, with back-to-back reads and no gaps.
  - Pushes 1 into the RD_LAT-deep valid pipeline (with a last flag when count==0).
  - After the final issue, go to RD_DRAIN.
- State RD_DRAIN: bus idle (all strobes high). When the last flag emerges from the pipeline, go to IDLE and pulse done in the same cycle as rd_last.
- Read return:
  - When a pipeline entry emerges, sample in_avm_readdata into rd_data and assert rd_valid for one cycle.
  - Reads issued at cycle T yield rd_valid at cycle T+RD_LAT.
- Strobes: write_n and read_n are never both low; chipselect_n is low exactly when one strobe is low.
- Address arithmetic: 16-bit, wraps 0xFFFF -> 0x0000 with no error.
- Block size: cmd_len=0 gives a single beat; cmd_len=2^LEN_W-1 gives the maximum beat count.
- Command timing: cmd_valid outside IDLE is ignored (cmd_ready=0); a command accepted in IDLE puts its first bus strobe on the next edge at the earliest.
- wr_valid outside WR: ignored, wr_ready=0.
- rst mid-block: the next edge forces reset values, in-flight read results are discarded (no rd_valid), and done is not pulsed.

Decomposition:
- Shared package: state enum (IDLE, WR, RD_ISSUE, RD_DRAIN), bus width constants (ADDR_W=16, DATA_W=8).
- Sub-module exram_rd_pipe: RD_LAT-deep valid/last shift register with sync reset, emitting rd_valid/rd_last strobes.

Test Plan:
- Write, addr 0x0010, cmd_len=3, wr_valid held high, bytes A0..A3 -> four consecutive write_n=0 cycles at addresses 0x10..0x13 with data A0..A3; done one cycle after the last strobe.
- Write, cmd_len=2, wr_valid toggling 1,0,1,0,1 -> strobes only in wr_valid cycles; address/data advance only on those cycles; a bubble (all strobes high) in between.
- Read, addr 0x0100, cmd_len=3, RD_LAT=2, slave model returns addr[7:0]^0x5A -> read_n low for 4 consecutive cycles; rd_valid in cycles T+2..T+5 with data 5A,5B,58,59; rd_last and done in T+5.
- Read, addr 0xFFFE, cmd_len=3 -> addresses FFFE, FFFF, 0000, 0001 issued; four rd_valid pulses.
- rst asserted 1 cycle after the second read issue of a cmd_len=7 read -> next edge: all strobes high, cmd_ready=1 after rst drops, no rd_valid and no done afterwards.
- cmd_valid held high throughout a block; then cmd_len=0 write followed immediately by cmd_len=0 read -> second command accepted only in IDLE; exactly one write strobe, one read strobe, and two done pulses.

Source files
------------

// File: rtl/avalon_master_exram_pkg.sv
// Shared types and bus widths for the external-RAM Avalon-MM master.
package avalon_master_exram_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_DRAIN
    } state_t;
endpackage

// File: rtl/exram_rd_pipe.sv
// Fixed-latency read-return tracker: a valid/last shift register whose far end
// marks the cycle in which the slave's read data must be captured.
module exram_rd_pipe #(
    parameter int unsigned RD_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  logic i_push_last,
    output logic o_rd_valid,
    output logic o_rd_last
);
    logic [RD_LAT-1:0] r_v;
    logic [RD_LAT-1:0] r_l;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v <= '0;
            r_l <= '0;
        end else begin
            r_v[0] <= i_push;
            r_l[0] <= i_push && i_push_last;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                r_v[i] <= r_v[i-1];
                r_l[i] <= r_l[i-1];
            end
        end
    end

    assign o_rd_valid = r_v[RD_LAT-1];
    assign o_rd_last  = r_l[RD_LAT-1];
endmodule

// File: rtl/avalon_master_exram.sv
// Avalon-MM block master for the external-RAM bridge: byte transfers with
// address auto-increment, streamed write data and pipelined fixed-latency reads.
module avalon_master_exram
    import avalon_master_exram_pkg::*;
#(
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              done,
    output logic              out_avm_chipselect_n,
    output logic              out_avm_write_n,
    output logic              out_avm_read_n,
    output logic [ADDR_W-1:0] out_avm_address,
    output logic [DATA_W-1:0] out_avm_writedata,
    input  logic [DATA_W-1:0] in_avm_readdata
);
    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_cnt;
    logic                r_wr_last;
    logic                r_cs_n;
    logic                r_write_n;
    logic                r_read_n;
    logic [ADDR_W-1:0]   r_address;
    logic [DATA_W-1:0]   r_writedata;
    logic                r_rd_valid;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_last;
    logic                r_done;
    logic                w_accept;
    logic                w_wr_beat;
    logic                w_push;
    logic                w_cnt_zero;
    logic                w_pipe_v;
    logic                w_pipe_last;

    assign cmd_ready  = (r_state == IDLE) && !rst;
    assign wr_ready   = (r_state == WR) && wr_valid && !rst;
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_wr_beat  = wr_ready;
    assign w_push     = (r_state == RD_ISSUE);
    assign w_cnt_zero = (r_cnt == '0);

    exram_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_last (w_cnt_zero),
        .o_rd_valid  (w_pipe_v),
        .o_rd_last   (w_pipe_last)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (w_accept) w_state_nxt = cmd_write ? WR : RD_ISSUE;
            WR:       if (w_wr_beat && w_cnt_zero) w_state_nxt = IDLE;
            RD_ISSUE: if (w_cnt_zero) w_state_nxt = RD_DRAIN;
            RD_DRAIN: if (w_pipe_last) w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_cnt       <= '0;
            r_wr_last   <= 1'b0;
            r_cs_n      <= 1'b1;
            r_write_n   <= 1'b1;
            r_read_n    <= 1'b1;
            r_address   <= '0;
            r_writedata <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_rd_last   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // Strobes default high each cycle so bubbles and drain are implicit.
            r_cs_n     <= 1'b1;
            r_write_n  <= 1'b1;
            r_read_n   <= 1'b1;
            r_wr_last  <= w_wr_beat && w_cnt_zero;
            r_done     <= r_wr_last || w_pipe_last;
            r_rd_valid <= w_pipe_v;
            r_rd_last  <= w_pipe_last;
            if (w_pipe_v) r_rd_data <= in_avm_readdata;
            if (w_accept) begin
                r_addr <= cmd_addr;
                r_cnt  <= cmd_len;
            end
            if (w_wr_beat) begin
                r_cs_n      <= 1'b0;
                r_write_n   <= 1'b0;
                r_address   <= r_addr;
                r_writedata <= wr_data;
                r_addr      <= r_addr + ADDR_W'(1);
                r_cnt       <= r_cnt - LEN_W'(1);
            end
            if (w_push) begin
                r_cs_n    <= 1'b0;
                r_read_n  <= 1'b0;
                r_address <= r_addr;
                r_addr    <= r_addr + ADDR_W'(1);
                r_cnt     <= r_cnt - LEN_W'(1);
            end
        end
    end

    assign out_avm_chipselect_n = r_cs_n;
    assign out_avm_write_n      = r_write_n;
    assign out_avm_read_n       = r_read_n;
    assign out_avm_address      = r_address;
    assign out_avm_writedata    = r_writedata;
    assign rd_valid             = r_rd_valid;
    assign rd_data              = r_rd_data;
    assign rd_last              = r_rd_last;
    assign done                 = r_done;
endmodule

// File: tb/tb_avalon_master_exram.sv
// Self-checking bench: transaction-level model of expected bus beats, read
// returns and done pulses, compared every cycle, plus directed literal checks.
module tb_avalon_master_exram;
    localparam int RD_LAT = 2;
    localparam int LEN_W  = 8;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        int          c;
        bit          l;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wr_valid, wr_ready;
    logic [7:0]  wr_data;
    logic        rd_valid, rd_last, done;
    logic [7:0]  rd_data;
    logic        cs_n, write_n, read_n;
    logic [15:0] address;
    logic [7:0]  writedata;
    logic [7:0]  readdata;
    logic [7:0]  slv_q = 8'h00;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    logic [7:0] wbase = 8'h00;

    ev_t exp_wr[$], exp_rd[$], ret_q[$];
    int  done_q[$];
    ev_t wr_log[$], rd_log[$], rv_log[$];
    int  done_log[$];

    avalon_master_exram #(.RD_LAT(RD_LAT), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .done(done),
        .out_avm_chipselect_n(cs_n), .out_avm_write_n(write_n), .out_avm_read_n(read_n),
        .out_avm_address(address), .out_avm_writedata(writedata),
        .in_avm_readdata(readdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave with one register stage: data for a read is presented the cycle after it.
    always @(posedge clk) if (cs_n === 1'b0 && read_n === 1'b0) slv_q <= address[7:0] ^ 8'h5A;
    assign readdata = slv_q;

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic chkeq(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk(act === exp, nm, act, exp);
    endtask

    always @(negedge clk) begin
        ev_t e;
        bit  expv, expd;
        chk((cs_n === (write_n & read_n)) && !(write_n === 1'b0 && read_n === 1'b0),
            "strobe_legal", {29'd0, cs_n, write_n, read_n}, 32'd0);
        if (write_n === 1'b0) begin
            wr_log.push_back('{a: address, d: writedata, c: cyc, l: 1'b0});
            if (exp_wr.size() == 0) chk(1'b0, "unexpected_write", 32'(address), 32'd0);
            else begin
                e = exp_wr.pop_front();
                chkeq("wr_addr", 32'(address), 32'(e.a));
                chkeq("wr_data", 32'(writedata), 32'(e.d));
                if (e.l) done_q.push_back(cyc + 1);
            end
        end
        if (read_n === 1'b0) begin
            rd_log.push_back('{a: address, d: 8'h00, c: cyc, l: 1'b0});
            if (exp_rd.size() == 0) chk(1'b0, "unexpected_read", 32'(address), 32'd0);
            else begin
                e = exp_rd.pop_front();
                chkeq("rd_addr", 32'(address), 32'(e.a));
                ret_q.push_back('{a: e.a, d: e.a[7:0] ^ 8'h5A, c: cyc + RD_LAT, l: e.l});
                if (e.l) done_q.push_back(cyc + RD_LAT);
            end
        end
        while (ret_q.size() > 0 && ret_q[0].c < cyc) void'(ret_q.pop_front());
        while (done_q.size() > 0 && done_q[0] < cyc) void'(done_q.pop_front());
        expv = (ret_q.size() > 0) && (ret_q[0].c == cyc);
        chkeq("rd_valid", 32'(rd_valid), 32'(expv));
        chkeq("rd_last", 32'(rd_last), expv ? 32'(ret_q[0].l) : 32'd0);
        if (rd_valid === 1'b1) rv_log.push_back('{a: 16'h0, d: rd_data, c: cyc, l: rd_last});
        if (expv) begin
            chkeq("rd_data", 32'(rd_data), 32'(ret_q[0].d));
            void'(ret_q.pop_front());
        end
        expd = (done_q.size() > 0) && (done_q[0] == cyc);
        chkeq("done", 32'(done), 32'(expd));
        if (done === 1'b1) done_log.push_back(cyc);
        if (expd) void'(done_q.pop_front());
        if (rst === 1'b1) begin
            exp_wr.delete(); exp_rd.delete(); ret_q.delete(); done_q.delete();
        end else if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
            for (int i = 0; i <= int'(cmd_len); i++) begin
                e = '{a: cmd_addr + 16'(i), d: wbase + 8'(i), c: 0, l: (i == int'(cmd_len))};
                if (cmd_write) exp_wr.push_back(e);
                else           exp_rd.push_back(e);
            end
        end
    end

    task automatic clear_logs();
        wr_log.delete(); rd_log.delete(); rv_log.delete(); done_log.delete();
    endtask

    task automatic wait_done(input int n);
        int k = 0;
        while (done_log.size() < n && k < 600) begin
            @(negedge clk); #1;
            k++;
        end
        chk(done_log.size() >= n, "done_timeout", 32'(done_log.size()), 32'(n));
    endtask

    task automatic run_block(input bit wr, input logic [15:0] a, input logic [7:0] len, input bit tog);
        int n = 0, idx = 0, ph = 0, d0;
        d0 = done_log.size();
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = len;
        wr_valid = wr; wr_data = wbase;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chkeq("cmd_accept", 32'(cmd_ready), 32'd1);
        if (wr) chkeq("wr_ready_idle", 32'(wr_ready), 32'd0);
        if (wr) while (idx <= int'(len) && ph < 2000) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            wr_valid  = tog ? (ph % 2 == 0) : 1'b1;
            wr_data   = wbase + 8'(idx);
            @(negedge clk);
            chkeq("wr_ready", 32'(wr_ready), 32'(wr_valid));
            if (wr_ready === 1'b1) idx++;
            ph++;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0; wr_valid = 1'b0;
        wait_done(d0 + 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  exp3 [4] = '{8'h5A, 8'h5B, 8'h58, 8'h59};
        logic [15:0] exp4 [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        int n;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0;

        @(negedge clk);
        chkeq("rst_bus", {29'd0, cs_n, write_n, read_n}, 32'd7);
        chkeq("rst_addr", 32'(address), 32'd0);
        chkeq("rst_wdata", 32'(writedata), 32'd0);
        chkeq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chkeq("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // Back-to-back write burst.
        @(posedge clk); #1; clear_logs(); wbase = 8'hA0;
        run_block(1'b1, 16'h0010, 8'd3, 1'b0);
        chkeq("t1_nwr", 32'(wr_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < wr_log.size(); i++) begin
            chkeq("t1_addr", 32'(wr_log[i].a), 32'h10 + 32'(i));
            chkeq("t1_data", 32'(wr_log[i].d), 32'hA0 + 32'(i));
            chkeq("t1_cyc", 32'(wr_log[i].c), 32'(wr_log[0].c + i));
        end
        if (wr_log.size() == 4 && done_log.size() == 1)
            chkeq("t1_done_cyc", 32'(done_log[0]), 32'(wr_log[3].c + 1));

        // Write with wr_valid toggling 1,0,1,0,1.
        clear_logs(); wbase = 8'hC0;
        run_block(1'b1, 16'h0040, 8'd2, 1'b1);
        chkeq("t2_nwr", 32'(wr_log.size()), 32'd3);
        for (int i = 1; i < 3 && i < wr_log.size(); i++) begin
            chkeq("t2_gap", 32'(wr_log[i].c - wr_log[i-1].c), 32'd2);
            chkeq("t2_addr", 32'(wr_log[i].a), 32'h40 + 32'(i));
            chkeq("t2_data", 32'(wr_log[i].d), 32'hC0 + 32'(i));
        end

        // Pipelined read burst.
        clear_logs();
        run_block(1'b0, 16'h0100, 8'd3, 1'b0);
        chkeq("t3_nrd", 32'(rd_log.size()), 32'd4);
        chkeq("t3_nrv", 32'(rv_log.size()), 32'd4);
        if (rd_log.size() == 4 && rv_log.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chkeq("t3_issue_cyc", 32'(rd_log[i].c), 32'(rd_log[0].c + i));
                chkeq("t3_rv_cyc", 32'(rv_log[i].c), 32'(rd_log[0].c + 2 + i));
                chkeq("t3_rdata", 32'(rv_log[i].d), 32'(exp3[i]));
            end
            chkeq("t3_last", 32'(rv_log[3].l), 32'd1);
            if (done_log.size() == 1) chkeq("t3_done_cyc", 32'(done_log[0]), 32'(rv_log[3].c));
        end

        // Address wrap.
        clear_logs();
        run_block(1'b0, 16'hFFFE, 8'd3, 1'b0);
        chkeq("t4_nrv", 32'(rv_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < rd_log.size(); i++)
            chkeq("t4_addr", 32'(rd_log[i].a), 32'(exp4[i]));

        // Maximum block length.
        clear_logs();
        run_block(1'b0, 16'h3000, 8'hFF, 1'b0);
        chkeq("tmax_nrv", 32'(rv_log.size()), 32'd256);

        // Reset in the middle of a read block.
        clear_logs();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0200; cmd_len = 8'd7;
        @(negedge clk);
        chkeq("t5_accept", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        n = 0;
        while (rd_log.size() < 2 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chkeq("t5_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chkeq("t5_bus_idle", {29'd0, cs_n, write_n, read_n}, 32'd7);
        chkeq("t5_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (12) @(negedge clk);
        #1;
        chkeq("t5_nrd", 32'(rd_log.size()), 32'd3);
        chkeq("t5_nrv", 32'(rv_log.size()), 32'd1);
        chkeq("t5_ndone", 32'(done_log.size()), 32'd0);

        // cmd_valid held across a block: single-beat write then single-beat read.
        @(posedge clk); #1; clear_logs(); wbase = 8'h77;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0500; cmd_len = 8'd0;
        wr_valid = 1'b1; wr_data = 8'h77;
        @(negedge clk);
        chkeq("t6_accept_wr", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_write = 1'b0; cmd_addr = 16'h0600;
        @(negedge clk);
        chkeq("t6_busy_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1 wr_valid = 1'b0;
        @(negedge clk);
        chkeq("t6_accept_rd", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        wait_done(2);
        repeat (4) @(negedge clk);
        #1;
        chkeq("t6_nwr", 32'(wr_log.size()), 32'd1);
        chkeq("t6_nrd", 32'(rd_log.size()), 32'd1);
        chkeq("t6_ndone", 32'(done_log.size()), 32'd2);
        if (rv_log.size() == 1) chkeq("t6_rdata", 32'(rv_log[0].d), 32'h5A);
        else chk(1'b0, "t6_nrv", 32'(rv_log.size()), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
